// File: rtl/disp_scan_if.sv
// Display scan bus: inputs the controller consumes and the outputs it drives.
//   digit_en   [7:0] per-digit enable
//   blink_mask [7:0] per-digit blink
//   seg_in     [6:0] pattern from the 8:1 mux for the selected digit
//   sel        [2:0] digit select to the mux s input
//   an_n       [7:0] active-low anode enables
//   seg_out    [6:0] segment pattern to the pins
//   frame_tick       one-cycle pulse per completed 8-digit frame
// master = scan controller side, slave = display/mux/system side.
interface disp_scan_if;
  logic [7:0] digit_en;
  logic [7:0] blink_mask;
  logic [6:0] seg_in;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic [6:0] seg_out;
  logic       frame_tick;

  modport master (
    input  digit_en, blink_mask, seg_in,
    output sel, an_n, seg_out, frame_tick
  );

  modport slave (
    output digit_en, blink_mask, seg_in,
    input  sel, an_n, seg_out, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexing controller for an 8-digit seven-segment display.
// Steps a 3-bit digit select every DIV cycles, blanks all anodes for the
// first BLANK cycles of each slot, gates digits by enable and blink, and
// registers the mux pattern so anodes and segments stay aligned.
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   disp_scan_if.master (digit_en, blink_mask, seg_in in;
//         sel, an_n, seg_out, frame_tick out, all registered)
module disp_scan_ctrl #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK        = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  disp_scan_if.master  bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pcnt;
  logic [2:0]    sel_q;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          ft_q;

  logic slot_end_c;
  logic frame_end_c;
  logic in_blank_c;
  logic active_c;

  assign slot_end_c  = (pcnt == PMAX);
  assign frame_end_c = slot_end_c && (sel_q == 3'd7);
  assign active_c    = bus.digit_en[sel_q] & ~(bus.blink_mask[sel_q] & blink_phase);

  // With no blanking the compare would be constant-false, so drop it entirely.
  generate
    if (BLANK == 0) begin : g_noblank
      assign in_blank_c = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] PBLANK = PW'(BLANK);
      assign in_blank_c = (pcnt < PBLANK);
    end
  endgenerate

  // Prescaler, digit select, frame/blink counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      sel_q       <= 3'd0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= 7'd0;
      ft_q        <= 1'b0;
    end else begin
      if (slot_end_c) begin
        pcnt  <= '0;
        sel_q <= sel_q + 3'd1;
      end else begin
        pcnt  <= pcnt + PW'(1);
      end

      if (frame_end_c) begin
        if (fcnt == FMAX) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end

      ft_q  <= frame_end_c;
      seg_q <= bus.seg_in;
      // One-hot-low anode for the current digit; never more than one low bit.
      if (in_blank_c || !active_c) an_q <= 8'hFF;
      else                         an_q <= ~(8'd1 << sel_q);
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an_n       = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.frame_tick = ft_q;

endmodule
